bmp_loader: RTL and testbench
=============================

BMP_LOADER -- requirements
Module: bmp_loader

Interface
REQ-001 SHALL have parameter BMP_W, default 1536, meaning the total bitmap width in bits (64 columns x 24 rows).
REQ-002 SHALL have parameter WORD_W, default 32, meaning the input word width; NUM_WORDS = BMP_W/WORD_W (48).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WORD_W  bitmap word from source.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_first  input  1  qualifies word as first of a bitmap (sampled only with in_valid).
REQ-008 in_ready  output  1  loader accepts word this cycle.
REQ-009 bitmap  output  BMP_W  assembled bitmap to comparator bitmap input.
REQ-010 wren  output  1  one-cycle load strobe to comparator wren.
REQ-011 cmp_done  input  1  comparator done.
REQ-012 busy  output  1  high from wren until comparison completes.
REQ-013 frame_cnt  output  8  count of bitmaps issued, wraps 255->0.

Function
REQ-014 A word SHALL be accepted only on a cycle with in_valid & in_ready.
REQ-015 The FSM SHALL have states FILL, LOAD and WAIT.
REQ-016 In FILL, in_ready SHALL be 1.
REQ-017 The accepted word SHALL be written to bitmap[idx*WORD_W +: WORD_W], then idx SHALL increment; word 0 lands at bitmap[31:0].
REQ-018 An accepted word with in_first=1 SHALL be written at index 0 and set idx to 1, discarding any partial fill, regardless of current idx.
REQ-019 When the word at idx = NUM_WORDS-1 is accepted (cycle N), the FSM SHALL go to LOAD, idx SHALL return to 0, and in_ready SHALL be 0 from N+1.
REQ-020 In LOAD (cycle N+1), wren SHALL be 1 for exactly one cycle with bitmap complete and stable; frame_cnt SHALL increment in the same cycle; the FSM SHALL then go to WAIT.
REQ-021 busy SHALL be 1 in LOAD and WAIT, and 0 in FILL.
REQ-022 The loader SHALL register cmp_done every cycle (done_q); in WAIT a rising edge (cmp_done & ~done_q) SHALL move the FSM to FILL on the next cycle, with in_ready=1 at M+1 for an edge at cycle M.
REQ-023 A cmp_done level already high on entry to WAIT SHALL NOT complete the wait; only a new rising edge SHALL.
REQ-024 A cmp_done edge in FILL or LOAD SHALL be ignored.
REQ-025 bitmap SHALL hold its value in LOAD and WAIT, and SHALL only be modified by accepted words in FILL.
REQ-026 in_valid, in_first and in_data SHALL be don't-care while in_ready=0.

Reset
REQ-027 On rst assertion, the block SHALL immediately enter FILL with idx=0, bitmap=0, wren=0, busy=0, frame_cnt=0 and done_q=0.
REQ-028 in_ready SHALL be 0 while rst is high, and 1 from the first clock after deassertion.
REQ-029 rst during FILL, LOAD or WAIT SHALL abort the current operation with no wren emitted; a pending wren in the same cycle SHALL be suppressed.

Structure
REQ-030 BMP_W, WORD_W, NUM_WORDS and the state encoding SHALL reside in a shared package with the comparator constants.
REQ-031 idx SHALL be $clog2(NUM_WORDS) bits wide.
REQ-032 The block SHALL use one sub-module, done_edge (cmp_done register plus rising-edge detect).
REQ-033 bitmap SHALL be written by indexed word write, not a shift register.

Verification
REQ-034 Reset, then 48 back-to-back words 0x00000001..0x00000030 with word 0 first -> wren one cycle after the last accept; bitmap[31:0]=1, bitmap[1535:1504]=0x30; frame_cnt=1; busy=1; in_ready=0.
REQ-035 During WAIT drive in_valid=1 for 10 cycles, then a cmp_done rising edge -> bitmap unchanged, in_ready=1 one cycle after the edge, busy=0.
REQ-036 Load 20 words, then a word with in_first=1 and 47 further words -> wren exactly once, with bitmap built only from the last 48 words.
REQ-037 Hold cmp_done=1 across entry to WAIT -> FSM stays in WAIT; drop cmp_done then raise it -> returns to FILL.
REQ-038 Assert rst at idx=30 and in WAIT -> all outputs 0 immediately; no wren; a subsequent 48-word load works and frame_cnt=1.
REQ-039 Issue 256 bitmaps -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/bmp_loader_pkg.sv
// Shared constants and state encoding for the bitmap loader and comparator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bmp_loader_pkg;

  // Comparator geometry; the bitmap is one bit per cell.
  localparam int CMP_COLS  = 64;
  localparam int CMP_ROWS  = 24;

  localparam int BMP_W     = CMP_COLS * CMP_ROWS;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = BMP_W / WORD_W;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/bmp_loader_done_edge.sv
// Registers the comparator done level and flags its rising edge.
// Latency: rise_o is combinational from d_i against the previous-cycle level.
// Backpressure: none; samples every cycle.
module done_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic done_q;

  // Previous-cycle copy of the done level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= d_i;
    end
  end

  assign rise_o = d_i & ~done_q;

endmodule

// File: rtl/bmp_loader.sv
// Assembles a bitmap from WORD_W-bit words and hands it to the comparator.
// Latency: wren one cycle after the last word is accepted.
// Backpressure: in_ready low from the cycle after the last word until a new cmp_done rising edge.
module bmp_loader
  import bmp_loader_pkg::*;
#(
  parameter int BMP_W  = bmp_loader_pkg::BMP_W,
  parameter int WORD_W = bmp_loader_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_first,
  output logic              in_ready,
  output logic [BMP_W-1:0]  bitmap,
  output logic              wren,
  input  logic              cmp_done,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int NWORDS = BMP_W / WORD_W;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      wr_idx;
  logic [BMP_W-1:0]   bitmap_q, bitmap_d;
  logic [7:0]         frame_q, frame_d;
  logic               rdy_en_q;
  logic               done_rise;

  done_edge u_done_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cmp_done),
    .rise_o (done_rise)
  );

  // State, fill index, bitmap and frame counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      idx_q    <= '0;
      bitmap_q <= '0;
      frame_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bitmap_q <= bitmap_d;
      frame_q  <= frame_d;
    end
  end

  // Holds in_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state, indexed word write and handshake outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bitmap_d = bitmap_q;
    frame_d  = frame_q;
    in_ready = 1'b0;
    wren     = 1'b0;
    busy     = 1'b0;
    // A first-flagged word restarts the fill at index 0.
    wr_idx   = in_first ? '0 : idx_q;

    case (state_q)
      ST_FILL: begin
        in_ready = rdy_en_q;
        if (in_valid && rdy_en_q) begin
          bitmap_d[wr_idx*WORD_W +: WORD_W] = in_data;
          if (wr_idx == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_LOAD;
            // Bumped on entry so the new count is visible alongside wren.
            frame_d = frame_q + 8'd1;
          end else begin
            idx_d = wr_idx + 1'b1;
          end
        end
      end
      ST_LOAD: begin
        wren    = 1'b1;
        busy    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        // Only a fresh edge counts; a level held since LOAD has done_q=1.
        if (done_rise) begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  assign bitmap    = bitmap_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_bmp_loader.sv
module tb_bmp_loader;
  import bmp_loader_pkg::*;

  localparam int BW = 1536;
  localparam int WW = 32;
  localparam int NW = NUM_WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_first;
  logic          in_ready;
  logic [BW-1:0] bitmap;
  logic          wren;
  logic          cmp_done;
  logic          busy;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  int wren_cnt = 0;
  int w0;
  logic [BW-1:0] exp_bmp;

  typedef struct {
    logic          vld;
    logic          first;
    logic [WW-1:0] dat;
    logic          done;
    logic          e_rdy;
    logic          e_wren;
    logic          e_busy;
  } vec_t;

  vec_t tbl[$];

  bmp_loader #(.BMP_W(BW), .WORD_W(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .bitmap    (bitmap),
    .wren      (wren),
    .cmp_done  (cmp_done),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Count load strobes as seen at each rising edge.
  always @(posedge clk) if (wren) wren_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic v, input logic f, input logic [WW-1:0] d,
                              input logic dn, input logic er, input logic ew, input logic eb);
    vec_t r;
    r.vld = v; r.first = f; r.dat = d; r.done = dn;
    r.e_rdy = er; r.e_wren = ew; r.e_busy = eb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_bmp(input string nm, input logic [BW-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < NW; i++)
      if (bad < 0 && bitmap[i*WW +: WW] !== exp[i*WW +: WW]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got 0x%0h expected 0x%0h", nm, bad,
               bitmap[bad*WW +: WW], exp[bad*WW +: WW]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input logic f);
    in_valid = 1'b1;
    in_first = f;
    in_data  = d;
    @(negedge clk);
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    tick;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic load_frame(input logic [WW-1:0] base);
    for (int i = 0; i < NW; i++) begin
      exp_bmp[i*WW +: WW] = base + WW'(i);
      send_word(base + WW'(i), i == 0);
    end
  endtask

  task automatic expect_load(input logic [7:0] fc);
    @(negedge clk);
    chk("load_wren", {63'd0, wren}, 64'd1);
    chk("load_busy", {63'd0, busy}, 64'd1);
    chk("load_ready", {63'd0, in_ready}, 64'd0);
    chk("load_frame_cnt", {56'd0, frame_cnt}, {56'd0, fc});
    chk_bmp("load_bitmap", exp_bmp);
    tick;
  endtask

  task automatic finish_wait;
    cmp_done = 1'b1;
    @(negedge clk);
    chk("wait_edge_busy", {63'd0, busy}, 64'd1);
    tick;
    cmp_done = 1'b0;
    chk("wait_done_ready", {63'd0, in_ready}, 64'd1);
    chk("wait_done_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_reset_and_release;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_before_first_clk", {63'd0, in_ready}, 64'd0);
    tick;
    chk("ready_after_first_clk", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_wren"}, {63'd0, wren}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_frame_cnt"}, {56'd0, frame_cnt}, 64'd0);
    chk_bmp({tag, "_bitmap"}, '0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; cmp_done = 1'b0;
    exp_bmp = '0;

    // Reset state and release timing.
    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    pulse_reset_and_release;

    // Table: 48 words, LOAD, 10 cycles of in_valid during WAIT, then done edge.
    for (int i = 0; i < NW; i++) begin
      tbl.push_back(mk(1'b1, i == 0, WW'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0));
      exp_bmp[i*WW +: WW] = WW'(i + 1);
    end
    tbl.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0));

    for (int r = 0; r < tbl.size(); r++) begin
      in_valid = tbl[r].vld;
      in_first = tbl[r].first;
      in_data  = tbl[r].dat;
      cmp_done = tbl[r].done;
      @(negedge clk);
      chk($sformatf("row%0d_ready", r), {63'd0, in_ready}, {63'd0, tbl[r].e_rdy});
      chk($sformatf("row%0d_wren", r), {63'd0, wren}, {63'd0, tbl[r].e_wren});
      chk($sformatf("row%0d_busy", r), {63'd0, busy}, {63'd0, tbl[r].e_busy});
      if (tbl[r].e_wren) begin
        chk("first_frame_cnt", {56'd0, frame_cnt}, 64'd1);
        chk("first_word0", {32'd0, bitmap[31:0]}, 64'h1);
        chk("first_word47", {32'd0, bitmap[1535:1504]}, 64'h30);
        chk_bmp("first_bitmap", exp_bmp);
      end
      tick;
    end
    in_valid = 1'b0; in_first = 1'b0; cmp_done = 1'b0;
    chk_bmp("wait_bitmap_hold", exp_bmp);
    chk("first_wren_count", 64'(wren_cnt), 64'd1);

    // Restart on in_first discards a 20-word partial fill.
    w0 = wren_cnt;
    for (int i = 0; i < 20; i++) send_word(32'h100 + 32'(i), i == 0);
    load_frame(32'h200);
    expect_load(8'd2);
    finish_wait;
    chk("restart_wren_count", 64'(wren_cnt), 64'(w0 + 1));

    // cmp_done held high across entry to WAIT does not complete it.
    cmp_done = 1'b1;
    load_frame(32'h300);
    expect_load(8'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_done_busy", {63'd0, busy}, 64'd1);
      chk("held_done_ready", {63'd0, in_ready}, 64'd0);
      tick;
    end
    cmp_done = 1'b0;
    tick;
    chk("dropped_done_busy", {63'd0, busy}, 64'd1);
    finish_wait;

    // Reset mid-fill at idx 30.
    w0 = wren_cnt;
    for (int i = 0; i < 30; i++) send_word(32'h400 + 32'(i), i == 0);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_fill");
    pulse_reset_and_release;
    chk("rst_fill_no_wren", 64'(wren_cnt), 64'(w0));

    // Full load after reset, then reset during WAIT.
    load_frame(32'h500);
    expect_load(8'd1);
    chk("post_rst_wren_count", 64'(wren_cnt), 64'(w0 + 1));
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_wait");
    pulse_reset_and_release;

    // Reset asserted during the LOAD cycle suppresses the strobe.
    w0 = wren_cnt;
    load_frame(32'h600);
    #1 rst = 1'b1;
    #1;
    chk("rst_load_wren", {63'd0, wren}, 64'd0);
    chk("rst_load_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    pulse_reset_and_release;
    tick;
    chk("rst_load_no_wren", 64'(wren_cnt), 64'(w0));

    // 256 frames wrap the counter back to 0.
    for (int f = 0; f < 256; f++) begin
      load_frame(32'(f) << 16);
      expect_load(8'(f + 1));
      finish_wait;
    end
    chk("frame_cnt_wrap", {56'd0, frame_cnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
